dzcpu_useq: RTL and testbench

Micro-sequencer for the dzcpu core. It fetches the opcode byte and converts it to a flow index through the opcode lookup (or the 0xCB lookup for CB-prefixed opcodes). It then steps a micro-address through the uop ROM, one uop per cycle, and decodes each uop's flow-control field into PC-increment, flag-update and end-of-flow actions. It also inserts the interrupt flow at instruction boundaries.

---
 rtl/dzcpu_useq.sv | 150 +++++++++++++++
 tb/tb_dzcpu_useq.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dzcpu_useq.sv
// ============================================================================
// Module  : dzcpu_useq
// Brief   : dzcpu micro-sequencer - opcode/CB dispatch, uop stepping,
//           flow-control decode and interrupt-flow insertion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dzcpu_useq #(
    parameter int                   UADDR_W      = 8,
    parameter int                   UOP_W        = 13,
    parameter logic [4:0]           JCB_OP       = 5'd2,
    parameter logic [UADDR_W-1:0]   INT_FLOW_IDX = 8'd172
) (
    input  logic                 iClock,
    input  logic                 iReset,
    input  logic [7:0]           iMemData,
    input  logic                 iMemReady,
    input  logic [UADDR_W-1:0]   iFlowIdx,
    input  logic [UADDR_W-1:0]   iCbFlowIdx,
    input  logic [UOP_W-1:0]     iUop,
    input  logic                 iStall,
    input  logic                 iFlagZ,
    input  logic                 iIntReq,
    output logic [7:0]           oMop,
    output logic [7:0]           oCbMop,
    output logic [UADDR_W-1:0]   oUaddr,
    output logic                 oUopValid,
    output logic [4:0]           oOperation,
    output logic [3:0]           oOperand,
    output logic                 oPcInc,
    output logic                 oFlagsUpdate,
    output logic                 oEof,
    output logic                 oIntAck,
    output logic                 oFault
);

    typedef enum logic [2:0] {
        S_FETCH    = 3'd0,
        S_DISPATCH = 3'd1,
        S_EXEC     = 3'd2,
        S_CBWAIT   = 3'd3,
        S_CBDISP   = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    localparam logic [3:0] F_INC        = 4'd1;
    localparam logic [3:0] F_EOF        = 4'd2;
    localparam logic [3:0] F_INC_EOF    = 4'd3;
    localparam logic [3:0] F_EOF_FU     = 4'd4;
    localparam logic [3:0] F_INC_EOF_FU = 4'd5;
    localparam logic [3:0] F_INC_EOF_Z  = 4'd6;
    localparam logic [3:0] F_INC_EOF_NZ = 4'd7;
    localparam logic [3:0] F_UPD_FLAGS  = 4'd8;

    state_t state, state_next;

    logic [3:0] flow;
    logic [4:0] op;
    logic       exec_go;
    logic       is_inc;
    logic       is_fu;
    logic       is_term;
    logic       is_jcb;
    logic       at_top;

    assign flow   = iUop[12:9];
    assign op     = iUop[8:4];
    assign at_top = (oUaddr == {UADDR_W{1'b1}});

    always_comb begin
        exec_go      = (state == S_EXEC) && !iStall;
        is_inc       = (flow == F_INC) || (flow == F_INC_EOF) || (flow == F_INC_EOF_FU) ||
                       (flow == F_INC_EOF_Z) || (flow == F_INC_EOF_NZ);
        is_fu        = (flow == F_EOF_FU) || (flow == F_INC_EOF_FU) || (flow == F_UPD_FLAGS);
        is_term      = (flow == F_EOF) || (flow == F_INC_EOF) || (flow == F_EOF_FU) ||
                       (flow == F_INC_EOF_FU) || ((flow == F_INC_EOF_Z) && iFlagZ) ||
                       ((flow == F_INC_EOF_NZ) && !iFlagZ);
        is_jcb       = !is_term && (op == JCB_OP);

        oUopValid    = 1'b0;
        oOperation   = 5'd0;
        oOperand     = 4'd0;
        oPcInc       = 1'b0;
        oFlagsUpdate = 1'b0;
        oEof         = 1'b0;
        oIntAck      = 1'b0;
        state_next   = state;

        case (state)
            S_FETCH:    if (iMemReady) state_next = S_DISPATCH;
            S_DISPATCH: state_next = S_EXEC;
            S_CBWAIT:   if (iMemReady) state_next = S_CBDISP;
            S_CBDISP:   state_next = S_EXEC;
            S_EXEC: begin
                if (exec_go) begin
                    // A CB dispatch uop is hidden from the datapath but its flow strobes still fire.
                    oUopValid    = !is_jcb;
                    oOperation   = is_jcb ? 5'd0 : op;
                    oOperand     = is_jcb ? 4'd0 : iUop[3:0];
                    oPcInc       = is_inc;
                    oFlagsUpdate = is_fu;
                    oEof         = is_term;
                    oIntAck      = is_term && iIntReq;
                    if (is_term)
                        state_next = iIntReq ? S_EXEC : S_FETCH;
                    else if (is_jcb)
                        state_next = S_CBWAIT;
                    else if (at_top)
                        state_next = S_HALT;
                end
            end
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state  <= S_FETCH;
            oUaddr <= '0;
            oMop   <= 8'd0;
            oCbMop <= 8'd0;
            oFault <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_FETCH:    if (iMemReady) oMop <= iMemData;
                S_DISPATCH: oUaddr <= iFlowIdx;
                S_CBWAIT:   if (iMemReady) oCbMop <= iMemData;
                S_CBDISP:   oUaddr <= iCbFlowIdx;
                S_EXEC: begin
                    if (exec_go) begin
                        if (is_term) begin
                            if (iIntReq) oUaddr <= INT_FLOW_IDX;
                        end else if (!is_jcb) begin
                            // No wrap past the top of the ROM: flag and freeze instead.
                            if (at_top) oFault <= 1'b1;
                            else        oUaddr <= oUaddr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dzcpu_useq.sv
// ============================================================================
// Module  : tb_dzcpu_useq
// Brief   : Directed self-checking bench for dzcpu_useq with a small uop ROM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dzcpu_useq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic [7:0]  flow_idx;
    logic [7:0]  cb_flow_idx;
    logic [12:0] uop;
    logic        stall;
    logic        flag_z;
    logic        int_req;
    logic [7:0]  mop;
    logic [7:0]  cb_mop;
    logic [7:0]  uaddr;
    logic        uop_valid;
    logic [4:0]  operation;
    logic [3:0]  operand;
    logic        pc_inc;
    logic        flags_update;
    logic        eof;
    logic        int_ack;
    logic        fault;

    logic [12:0] rom    [256];
    logic [7:0]  optab  [256];
    logic [7:0]  cbtab  [256];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign uop         = rom[uaddr];
    assign flow_idx    = optab[mop];
    assign cb_flow_idx = cbtab[cb_mop];

    dzcpu_useq dut (
        .iClock      (clk),
        .iReset      (rst_n),
        .iMemData    (mem_data),
        .iMemReady   (mem_ready),
        .iFlowIdx    (flow_idx),
        .iCbFlowIdx  (cb_flow_idx),
        .iUop        (uop),
        .iStall      (stall),
        .iFlagZ      (flag_z),
        .iIntReq     (int_req),
        .oMop        (mop),
        .oCbMop      (cb_mop),
        .oUaddr      (uaddr),
        .oUopValid   (uop_valid),
        .oOperation  (operation),
        .oOperand    (operand),
        .oPcInc      (pc_inc),
        .oFlagsUpdate(flags_update),
        .oEof        (eof),
        .oIntAck     (int_ack),
        .oFault      (fault)
    );

    function automatic logic [12:0] mk(input logic [3:0] f, input logic [4:0] o, input logic [3:0] a);
        return {f, o, a};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [7:0] opc);
        mem_data  = opc;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks++;
        if (uaddr !== 8'd0 || mop !== 8'd0 || cb_mop !== 8'd0 || fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: uaddr=%h mop=%h cbmop=%h fault=%b required 00 00 00 0", uaddr, mop, cb_mop, fault);
        end
        checks++;
        if ({uop_valid, pc_inc, flags_update, eof, int_ack} !== 5'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b required 00000", {uop_valid, pc_inc, flags_update, eof, int_ack});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        mem_data  = 8'h31;
        mem_ready = 1'b1;
        #1;
        checks++;
        if (uop_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_no_uop: valid=%b required 0", uop_valid);
        end
        tick();
        mem_ready = 1'b0;
        checks++;
        if (mop !== 8'h31) begin
            errors++;
            $display("FAIL mop_latch: got %h required 31", mop);
        end
        tick();
        checks++;
        if (uaddr !== 8'd1 || uop_valid !== 1'b1 || operation !== 5'd1 || operand !== 4'd3 || pc_inc !== 1'b0 || eof !== 1'b0) begin
            errors++;
            $display("FAIL basic_u1: uaddr=%0d v=%b op=%0d opnd=%0d inc=%b eof=%b required 1 1 1 3 0 0",
                     uaddr, uop_valid, operation, operand, pc_inc, eof);
        end
        tick();
        checks++;
        if (uaddr !== 8'd2 || uop_valid !== 1'b1 || pc_inc !== 1'b1 || eof !== 1'b0) begin
            errors++;
            $display("FAIL basic_u2: uaddr=%0d v=%b inc=%b eof=%b required 2 1 1 0", uaddr, uop_valid, pc_inc, eof);
        end
        tick();
        checks++;
        if (uaddr !== 8'd3 || uop_valid !== 1'b1 || pc_inc !== 1'b1 || eof !== 1'b1 || flags_update !== 1'b0) begin
            errors++;
            $display("FAIL basic_u3: uaddr=%0d v=%b inc=%b eof=%b fu=%b required 3 1 1 1 0",
                     uaddr, uop_valid, pc_inc, eof, flags_update);
        end
        tick();
        checks++;
        if (uop_valid !== 1'b0 || pc_inc !== 1'b0 || eof !== 1'b0) begin
            errors++;
            $display("FAIL basic_back_to_fetch: v=%b inc=%b eof=%b required 0 0 0", uop_valid, pc_inc, eof);
        end
    endtask

    task automatic test_cond_z();
        flag_z = 1'b1;
        fetch(8'h20);
        checks++;
        if (uaddr !== 8'd19 || uop_valid !== 1'b1 || pc_inc !== 1'b1 || eof !== 1'b1) begin
            errors++;
            $display("FAIL condz_taken: uaddr=%0d v=%b inc=%b eof=%b required 19 1 1 1", uaddr, uop_valid, pc_inc, eof);
        end
        tick();
        checks++;
        if (uop_valid !== 1'b0 || uaddr !== 8'd19) begin
            errors++;
            $display("FAIL condz_no_u20: v=%b uaddr=%0d required 0 19", uop_valid, uaddr);
        end
        flag_z = 1'b0;
        fetch(8'h20);
        checks++;
        if (uaddr !== 8'd19 || uop_valid !== 1'b1 || pc_inc !== 1'b1 || eof !== 1'b0) begin
            errors++;
            $display("FAIL condz_not_taken: uaddr=%0d v=%b inc=%b eof=%b required 19 1 1 0", uaddr, uop_valid, pc_inc, eof);
        end
        for (int i = 20; i <= 21; i++) begin
            tick();
            checks++;
            if (uaddr !== 8'(i) || uop_valid !== 1'b1 || eof !== 1'b0) begin
                errors++;
                $display("FAIL condz_step: uaddr=%0d v=%b eof=%b required %0d 1 0", uaddr, uop_valid, eof, i);
            end
        end
        tick();
        checks++;
        if (uaddr !== 8'd22 || eof !== 1'b1 || pc_inc !== 1'b0) begin
            errors++;
            $display("FAIL condz_end: uaddr=%0d eof=%b inc=%b required 22 1 0", uaddr, eof, pc_inc);
        end
        tick();
    endtask

    task automatic test_cb();
        fetch(8'hCB);
        checks++;
        if (uaddr !== 8'd15 || uop_valid !== 1'b0 || eof !== 1'b0) begin
            errors++;
            $display("FAIL cb_jcb_hidden: uaddr=%0d v=%b eof=%b required 15 0 0", uaddr, uop_valid, eof);
        end
        tick();
        mem_data  = 8'h7C;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        checks++;
        if (cb_mop !== 8'h7C || uop_valid !== 1'b0) begin
            errors++;
            $display("FAIL cb_latch: cbmop=%h v=%b required 7c 0", cb_mop, uop_valid);
        end
        tick();
        checks++;
        if (uaddr !== 8'd16 || uop_valid !== 1'b1 || flags_update !== 1'b1 || eof !== 1'b1 || operation !== 5'd3) begin
            errors++;
            $display("FAIL cb_eof_fu: uaddr=%0d v=%b fu=%b eof=%b op=%0d required 16 1 1 1 3",
                     uaddr, uop_valid, flags_update, eof, operation);
        end
        tick();
    endtask

    task automatic test_stall();
        fetch(8'h40);
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (uaddr !== 8'd51 || uop_valid !== 1'b0 || pc_inc !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: uaddr=%0d v=%b inc=%b required 51 0 0", i, uaddr, uop_valid, pc_inc);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++;
        if (uaddr !== 8'd51 || uop_valid !== 1'b1 || pc_inc !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume: uaddr=%0d v=%b inc=%b required 51 1 1", uaddr, uop_valid, pc_inc);
        end
        tick();
        checks++;
        if (uaddr !== 8'd52 || uop_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_next: uaddr=%0d v=%b required 52 1", uaddr, uop_valid);
        end
        tick();
        checks++;
        if (uaddr !== 8'd53 || eof !== 1'b1) begin
            errors++;
            $display("FAIL stall_end: uaddr=%0d eof=%b required 53 1", uaddr, eof);
        end
        tick();
    endtask

    task automatic test_interrupt();
        fetch(8'h31);
        int_req = 1'b1;
        #1;
        checks++;
        if (int_ack !== 1'b0) begin
            errors++;
            $display("FAIL int_midflow: ack=%b required 0", int_ack);
        end
        tick();
        tick();
        checks++;
        if (uaddr !== 8'd3 || eof !== 1'b1 || int_ack !== 1'b1) begin
            errors++;
            $display("FAIL int_ack: uaddr=%0d eof=%b ack=%b required 3 1 1", uaddr, eof, int_ack);
        end
        tick();
        int_req = 1'b0;
        #1;
        checks++;
        if (uaddr !== 8'd172 || uop_valid !== 1'b1 || int_ack !== 1'b0) begin
            errors++;
            $display("FAIL int_flow_entry: uaddr=%0d v=%b ack=%b required 172 1 0", uaddr, uop_valid, int_ack);
        end
        tick();
        checks++;
        if (uaddr !== 8'd173 || eof !== 1'b1 || int_ack !== 1'b0) begin
            errors++;
            $display("FAIL int_flow_end: uaddr=%0d eof=%b ack=%b required 173 1 0", uaddr, eof, int_ack);
        end
        tick();
    endtask

    task automatic test_fault_and_reset();
        fetch(8'h40);
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (uaddr !== 8'd0 || uop_valid !== 1'b0 || pc_inc !== 1'b0) begin
            errors++;
            $display("FAIL reset_midflow: uaddr=%0d v=%b inc=%b required 0 0 0", uaddr, uop_valid, pc_inc);
        end
        tick();
        rst_n = 1'b1;
        tick();
        fetch(8'hF0);
        tick();
        tick();
        checks++;
        if (uaddr !== 8'hFF || uop_valid !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL fault_top_uop: uaddr=%h v=%b fault=%b required ff 1 0", uaddr, uop_valid, fault);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (fault !== 1'b1 || uop_valid !== 1'b0 || uaddr !== 8'hFF) begin
                errors++;
                $display("FAIL fault_halt%0d: fault=%b v=%b uaddr=%h required 1 0 ff", i, fault, uop_valid, uaddr);
            end
        end
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || uaddr !== 8'd0) begin
            errors++;
            $display("FAIL fault_async_clear: fault=%b uaddr=%h required 0 00", fault, uaddr);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            rom[i]   = 13'd0;
            optab[i] = 8'd0;
            cbtab[i] = 8'd0;
        end
        optab[8'h31] = 8'd1;   rom[1]   = mk(4'd0, 5'd1, 4'd3);
                               rom[2]   = mk(4'd1, 5'd4, 4'd0);
                               rom[3]   = mk(4'd3, 5'd5, 4'd1);
        optab[8'h20] = 8'd19;  rom[19]  = mk(4'd6, 5'd6, 4'd0);
                               rom[20]  = mk(4'd0, 5'd7, 4'd0);
                               rom[21]  = mk(4'd0, 5'd8, 4'd0);
                               rom[22]  = mk(4'd2, 5'd9, 4'd0);
        optab[8'hCB] = 8'd15;  rom[15]  = mk(4'd0, 5'd2, 4'd0);
        cbtab[8'h7C] = 8'd16;  rom[16]  = mk(4'd4, 5'd3, 4'd2);
        optab[8'h40] = 8'd50;  rom[50]  = mk(4'd0, 5'd1, 4'd0);
                               rom[51]  = mk(4'd1, 5'd1, 4'd0);
                               rom[52]  = mk(4'd0, 5'd1, 4'd0);
                               rom[53]  = mk(4'd3, 5'd1, 4'd0);
                               rom[172] = mk(4'd0, 5'd10, 4'd0);
                               rom[173] = mk(4'd2, 5'd11, 4'd0);
        optab[8'hF0] = 8'hFD;  rom[253] = mk(4'd0, 5'd1, 4'd0);
                               rom[254] = mk(4'd0, 5'd1, 4'd0);
                               rom[255] = mk(4'd0, 5'd1, 4'd0);

        rst_n     = 1'b0;
        mem_data  = 8'd0;
        mem_ready = 1'b0;
        stall     = 1'b0;
        flag_z    = 1'b0;
        int_req   = 1'b0;

        test_reset();
        test_basic();
        test_cond_z();
        test_cb();
        test_stall();
        test_interrupt();
        test_fault_and_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
